uart_rx_frame: RTL and testbench

Serial receive controller for the UART path. It consumes the 1-bit line produced by the UART TX stage (idle high, start bit, data LSB-first, optional parity, stop bit) and delivers parallel bytes to the system with a one-cycle valid pulse. The block runs on an oversampled clock, recovers bit timing from the start-bit falling edge, and majority-votes three samples per bit. It reports parity and stop (framing) errors.

---
 rtl/uart_rx_frame.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver: recovers bit timing from the start edge, majority-votes
// three mid-bit samples and reports completed bytes, parity errors and framing errors.
module uart_rx_frame #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             data_valid,
  output logic             par_err,
  output logic             stp_err,
  output logic             busy
);

  localparam int H  = PRESCALE / 2;
  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] EDGE_S0   = EW'(H - 1);
  localparam logic [EW-1:0] EDGE_S2   = EW'(H + 1);
  localparam logic [EW-1:0] EDGE_EVAL = EW'(H + 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state, next_state;

  logic             sync_a, rx_s, rx_prev;
  logic [1:0]       fill;
  logic [EW-1:0]    edge_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [2:0]       samp;
  logic [WIDTH-1:0] shift_q;
  logic             par_en_q, par_typ_q, par_bad;

  logic fall, vote, bit_end, eval_pt;
  logic capture, confirm, shift_en, par_chk, stop_eval, busy_next;

  // rx_prev is held at 0 until the synchronizer holds real line samples, so a line
  // that is low coming out of reset is never taken as a start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a  <= 1'b1;
      rx_s    <= 1'b1;
      fill    <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      sync_a  <= RX_IN;
      rx_s    <= sync_a;
      fill    <= {fill[0], 1'b1};
      rx_prev <= fill[1] ? rx_s : 1'b0;
    end
  end

  assign fall    = rx_prev & ~rx_s;
  assign vote    = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign bit_end = (edge_cnt == EDGE_LAST);
  assign eval_pt = (edge_cnt == EDGE_EVAL);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (fall) next_state = S_START;
      S_START:  if (bit_end) next_state = vote ? S_IDLE : S_DATA;
      S_DATA:   if (bit_end && (bit_cnt == BIT_LAST))
                  next_state = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) next_state = S_STOP;
      S_STOP:   if (eval_pt) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    capture   = 1'b0;
    confirm   = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_eval = 1'b0;
    busy_next = (next_state != S_IDLE);
    if (state != S_IDLE)
      capture = (edge_cnt >= EDGE_S0) && (edge_cnt <= EDGE_S2);
    case (state)
      S_START:  confirm   = bit_end & ~vote;
      S_DATA:   shift_en  = bit_end;
      S_PARITY: par_chk   = bit_end;
      S_STOP:   stop_eval = eval_pt;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samp       <= 3'b000;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= busy_next;

      // The detecting cycle is edge 0, so the first START cycle already sits at edge 1.
      if (state == S_IDLE)           edge_cnt <= fall ? EW'(1) : '0;
      else if (next_state == S_IDLE) edge_cnt <= '0;
      else if (bit_end)              edge_cnt <= '0;
      else                           edge_cnt <= edge_cnt + 1'b1;

      if (capture) samp <= {samp[1:0], rx_s};

      if (confirm) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_bad   <= 1'b0;
        bit_cnt   <= '0;
      end

      if (shift_en) begin
        shift_q <= {vote, shift_q[WIDTH-1:1]};
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end

      if (par_chk) par_bad <= vote ^ (^shift_q) ^ par_typ_q;

      if (stop_eval) begin
        if (!par_bad && vote) begin
          P_DATA     <= shift_q;
          data_valid <= 1'b1;
        end
        par_err <= par_bad;
        stp_err <= ~vote;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: drives serial frames, queues the expected result and arrival
// cycle of each frame, and compares them against every flag/valid event the receiver emits.
module tb_uart_rx_frame;

  localparam int W = 8;
  localparam int P = 8;
  localparam int H = P / 2;

  // Valid/flag contract: each completed frame yields exactly one cycle in which
  // data_valid, par_err and/or stp_err are high; there is no ready/back-pressure.
  logic         CLK, RST, RX_IN, PAR_EN, PAR_TYP;
  logic [W-1:0] P_DATA;
  logic         data_valid, par_err, stp_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_run = 0;
  int last_busy = 0;

  logic [W+2:0] exp_q[$];
  int           exp_t_q[$];
  logic [W-1:0] last_good;

  uart_rx_frame #(.WIDTH(W), .PRESCALE(P)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each output event pops one expected {stp,par,valid,data} and arrival cycle.
  always @(negedge CLK) begin : monitor
    logic [W+2:0] obs;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    if (!RST && (data_valid || par_err || stp_err)) begin
      obs = {stp_err, par_err, data_valid, P_DATA};
      if (exp_q.size() == 0) check_eq("spurious_event", 32'(obs), 32'd0);
      else begin
        check_eq("frame_result", 32'(obs), 32'(exp_q.pop_front()));
        check_eq("frame_latency", cyc, exp_t_q.pop_front());
      end
    end
  end

  // Drivers
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_bit(input logic v, input int glitch_at);
    for (int j = 0; j < P; j++) begin
      RX_IN = (j == glitch_at) ? ~v : v;
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic ptyp,
                            input logic par_bit, input logic stop_bit, input int stop_len,
                            input int gbit, input logic flip);
    logic par_ok, ok;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    par_ok  = !pen || (par_bit == ((^d) ^ ptyp));
    ok      = par_ok && stop_bit;
    if (ok) last_good = d;
    exp_q.push_back({~stop_bit, ~par_ok, ok, last_good});
    exp_t_q.push_back(cyc + 2 + (1 + W + int'(pen)) * P + H + 3);
    drive_bit(1'b0, -1);
    for (int i = 0; i < W; i++) begin
      drive_bit(d[i], (i == gbit) ? H : -1);
      if (flip && i == 1) begin
        PAR_EN  = ~pen;
        PAR_TYP = ~ptyp;
      end
    end
    if (pen) drive_bit(par_bit, -1);
    for (int j = 0; j < stop_len; j++) begin
      RX_IN = stop_bit;
      @(negedge CLK);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_p_data"}, 32'(P_DATA), 32'd0);
    check_eq({tag, "_valid"}, 32'(data_valid), 32'd0);
    check_eq({tag, "_par_err"}, 32'(par_err), 32'd0);
    check_eq({tag, "_stp_err"}, 32'(stp_err), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; last_good = '0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    idle(16);

    // Plain frame, busy spans start edge + 1 through stop evaluation
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, P, -1, 1'b0);
    idle(16);
    check_eq("busy_len_frame", last_busy, (1 + W) * P + H + 2);
    check_eq("busy_after_frame", 32'(busy), 32'd0);

    // Parity: even good, even bad, odd good, config flipped mid-frame, both errors
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, P, -1, 1'b0);
    idle(16);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, P, -1, 1'b0);
    idle(16);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, P, -1, 1'b0);
    idle(16);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, P, -1, 1'b1);
    idle(16);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, P, -1, 1'b0);
    idle(16);

    // Framing error, then a held-low line must not start a frame
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, P, -1, 1'b0);
    RX_IN = 1'b0;
    repeat (3 * P) @(negedge CLK);
    check_eq("break_not_busy", 32'(busy), 32'd0);
    idle(16);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, P, -1, 1'b0);
    idle(16);

    // Two-cycle glitch on an idle line is rejected in START
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(24);
    check_eq("glitch_busy_len", last_busy, P - 1);
    check_eq("glitch_busy_idle", 32'(busy), 32'd0);

    // Single-cycle inversion at the centre sample is outvoted
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, P, 3, 1'b0);
    idle(16);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, P, 6, 1'b0);
    idle(16);

    // Back-to-back: next start edge lands on the first IDLE cycle after stop evaluation
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, H + 3, -1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, P, -1, 1'b0);
    idle(16);

    // Reset in the middle of the data bits of 0x77
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b1, -1);
    RST = 1'b1;
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    last_good = '0;
    check_all_zero("mid_reset");
    idle(16);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, P, -1, 1'b0);
    idle(24);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
